// File: rtl/mc_control_rv32_pkg.sv
// Shared types for the multicycle RV32I control unit: state encoding, opcodes,
// mux-select codes, trap causes and the registered Moore output bundle.
package rv_ctrl_pkg;

  typedef enum logic [4:0] {
    S_FETCH     = 5'd0,
    S_DECODE    = 5'd1,
    S_MEM_ADR   = 5'd2,
    S_MEM_RD    = 5'd3,
    S_MEM_WB    = 5'd4,
    S_MEM_WR    = 5'd5,
    S_EXECUTE_R = 5'd6,
    S_EXECUTE_I = 5'd7,
    S_EXECUTE_M = 5'd8,
    S_ALU_WB    = 5'd9,
    S_BRANCH    = 5'd10,
    S_JAL       = 5'd11,
    S_JALR      = 5'd12,
    S_LINK      = 5'd13,
    S_LUI       = 5'd14,
    S_AUIPC     = 5'd15,
    S_TRAP      = 5'd16
  } state_e;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_RDATA  = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;
  localparam logic [1:0] RES_MD     = 2'b11;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_RS1   = 2'b01;
  localparam logic [1:0] SRCA_OLDPC = 2'b10;
  localparam logic [1:0] SRCA_ZERO  = 2'b11;
  localparam logic [1:0] SRCB_RS2   = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_U = 3'b011;
  localparam logic [2:0] IMM_J = 3'b100;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b1000;

  localparam logic [1:0] TRAP_NONE    = 2'b00;
  localparam logic [1:0] TRAP_ILLEGAL = 2'b01;
  localparam logic [1:0] TRAP_MEM_TO  = 2'b10;

  typedef struct packed {
    logic       mem_req;
    logic       mem_write;
    logic       adr_src;
    logic       pc_write;
    logic       reg_write;
    logic       retire;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [3:0] alu_control;
  } moore_t;

  function automatic logic is_mem_state(state_e s);
    return (s == S_FETCH) || (s == S_MEM_RD) || (s == S_MEM_WR);
  endfunction

  // Unconditional per-state outputs; handshake-qualified strobes are added at the top.
  function automatic moore_t moore_out(state_e s, logic [3:0] alu_r, logic [3:0] alu_i);
    moore_t o;
    o = '0;
    o.alu_control = ALU_ADD;
    case (s)
      S_FETCH:     begin o.mem_req = 1'b1; o.alu_src_b = SRCB_FOUR; o.result_src = RES_ALU; end
      S_DECODE:    begin o.alu_src_a = SRCA_OLDPC; o.alu_src_b = SRCB_IMM; end
      S_MEM_ADR:   begin o.alu_src_a = SRCA_RS1; o.alu_src_b = SRCB_IMM; end
      S_MEM_RD:    begin o.mem_req = 1'b1; o.adr_src = 1'b1; end
      S_MEM_WR:    begin o.mem_req = 1'b1; o.adr_src = 1'b1; o.mem_write = 1'b1; end
      S_MEM_WB:    begin o.result_src = RES_RDATA; o.reg_write = 1'b1; o.retire = 1'b1; end
      S_EXECUTE_R: begin o.alu_src_a = SRCA_RS1; o.alu_src_b = SRCB_RS2; o.alu_control = alu_r; end
      S_EXECUTE_I: begin o.alu_src_a = SRCA_RS1; o.alu_src_b = SRCB_IMM; o.alu_control = alu_i; end
      S_EXECUTE_M: o.result_src = RES_MD;
      S_ALU_WB:    begin o.result_src = RES_ALUOUT; o.reg_write = 1'b1; o.retire = 1'b1; end
      S_BRANCH:    begin
        o.alu_src_a = SRCA_RS1; o.alu_src_b = SRCB_RS2; o.alu_control = ALU_SUB; o.retire = 1'b1;
      end
      S_JAL:       begin o.pc_write = 1'b1; o.alu_src_a = SRCA_OLDPC; o.alu_src_b = SRCB_FOUR; end
      S_JALR:      begin
        o.pc_write = 1'b1; o.result_src = RES_ALU; o.alu_src_a = SRCA_RS1; o.alu_src_b = SRCB_IMM;
      end
      S_LINK:      begin o.alu_src_a = SRCA_OLDPC; o.alu_src_b = SRCB_FOUR; end
      S_LUI:       begin o.alu_src_a = SRCA_ZERO; o.alu_src_b = SRCB_IMM; end
      S_AUIPC:     begin o.alu_src_a = SRCA_OLDPC; o.alu_src_b = SRCB_IMM; end
      default:     o = '0;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/mc_control_rv32_if.sv
// Control-unit <-> datapath/memory bundle. master = control unit, slave = datapath side.
interface mc_control_rv32_if;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       zero, lt, ltu;
  logic       mem_ready, md_done;
  logic       mem_req, mem_write, adr_src;
  logic       ir_write, pc_write, reg_write;
  logic [1:0] result_src, alu_src_a, alu_src_b;
  logic [3:0] alu_control;
  logic [2:0] imm_src;
  logic       md_start, retire;
  logic [1:0] trap_cause;
  logic [4:0] current_state;

  modport master (
    input  opcode, funct3, funct7, zero, lt, ltu, mem_ready, md_done,
    output mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
           result_src, alu_src_a, alu_src_b, alu_control, imm_src,
           md_start, retire, trap_cause, current_state
  );

  modport slave (
    output opcode, funct3, funct7, zero, lt, ltu, mem_ready, md_done,
    input  mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
           result_src, alu_src_a, alu_src_b, alu_control, imm_src,
           md_start, retire, trap_cause, current_state
  );
endinterface

// File: rtl/mc_control_rv32_decode.sv
// Combinational IR decode: legality, dispatch target, imm_src and ALU op.
// CTRL_MULDIV_EN makes funct7=0000001 on OP legal and dispatches it to EXECUTE_M.
module ctrl_decode
  import rv_ctrl_pkg::*;
(
  input  logic [6:0] opcode_i,
  input  logic [2:0] funct3_i,
  input  logic [6:0] funct7_i,
  output logic       legal_o,
  output state_e     target_o,
  output logic [2:0] imm_src_o,
  output logic [3:0] alu_ctl_r_o,
  output logic [3:0] alu_ctl_i_o
);

  assign alu_ctl_r_o = {funct7_i[5], funct3_i};
  // funct7[5] only selects SRA over SRL; for other I-ops those bits are immediate
  assign alu_ctl_i_o = {(funct3_i == 3'b101) & funct7_i[5], funct3_i};

  always_comb begin
    legal_o   = 1'b0;
    target_o  = S_TRAP;
    imm_src_o = IMM_I;
    case (opcode_i)
      OP_LOAD: begin
        target_o = S_MEM_ADR;
        legal_o  = !(funct3_i inside {3'b011, 3'b110, 3'b111});
      end
      OP_STORE: begin
        target_o  = S_MEM_ADR;
        imm_src_o = IMM_S;
        legal_o   = funct3_i < 3'b011;
      end
      OP_OP: begin
        target_o = S_EXECUTE_R;
        case (funct7_i)
          7'b0000000: legal_o = 1'b1;
          7'b0100000: legal_o = (funct3_i == 3'b000) || (funct3_i == 3'b101);
`ifdef CTRL_MULDIV_EN
          7'b0000001: begin legal_o = 1'b1; target_o = S_EXECUTE_M; end
`endif
          default:    legal_o = 1'b0;
        endcase
      end
      OP_OPIMM: begin
        target_o = S_EXECUTE_I;
        case (funct3_i)
          3'b001:  legal_o = (funct7_i == 7'b0000000);
          3'b101:  legal_o = (funct7_i == 7'b0000000) || (funct7_i == 7'b0100000);
          default: legal_o = 1'b1;
        endcase
      end
      OP_BRANCH: begin
        target_o  = S_BRANCH;
        imm_src_o = IMM_B;
        legal_o   = !(funct3_i inside {3'b010, 3'b011});
      end
      OP_JAL:   begin target_o = S_JAL;   imm_src_o = IMM_J; legal_o = 1'b1; end
      OP_JALR:  begin target_o = S_JALR;  legal_o = 1'b1; end
      OP_LUI:   begin target_o = S_LUI;   imm_src_o = IMM_U; legal_o = 1'b1; end
      OP_AUIPC: begin target_o = S_AUIPC; imm_src_o = IMM_U; legal_o = 1'b1; end
      default:  legal_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/mc_control_rv32.sv
// Multicycle RV32I control FSM with memory handshake timeout and sticky trap.
// Define CTRL_MULDIV_EN to enable the EXECUTE_M mul/div sequencing.
module mc_control_rv32
  import rv_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  mc_control_rv32_if.master ctl
);

  localparam int unsigned CW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam moore_t OUT_RST = moore_out(S_FETCH, ALU_ADD, ALU_ADD);

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [1:0]      cause_q, cause_d;
  moore_t          out_q, out_d;
  logic            md_start_q, md_start_d;

  logic            dec_legal;
  state_e          dec_target;
  logic [2:0]      dec_imm;
  logic [3:0]      dec_alu_r, dec_alu_i;
  logic            md_done_w, timeout, taken, run;

  ctrl_decode u_dec (
    .opcode_i    (ctl.opcode),
    .funct3_i    (ctl.funct3),
    .funct7_i    (ctl.funct7),
    .legal_o     (dec_legal),
    .target_o    (dec_target),
    .imm_src_o   (dec_imm),
    .alu_ctl_r_o (dec_alu_r),
    .alu_ctl_i_o (dec_alu_i)
  );

`ifdef CTRL_MULDIV_EN
  assign md_done_w  = ctl.md_done;
  assign md_start_d = (state_d == S_EXECUTE_M) && (state_q != S_EXECUTE_M);
`else
  logic unused_md_done;
  assign unused_md_done = ctl.md_done;
  assign md_done_w      = 1'b0;
  assign md_start_d     = 1'b0;
`endif

  // mem_ready arriving in the limit cycle wins over the timeout
  assign timeout = (MEM_TIMEOUT != 0) && (cnt_q == CW'(MEM_TIMEOUT)) && !ctl.mem_ready;

  always_comb begin
    case (ctl.funct3)
      3'b000:  taken = ctl.zero;
      3'b001:  taken = !ctl.zero;
      3'b100:  taken = ctl.lt;
      3'b101:  taken = !ctl.lt;
      3'b110:  taken = ctl.ltu;
      3'b111:  taken = !ctl.ltu;
      default: taken = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    case (state_q)
      S_FETCH, S_MEM_RD, S_MEM_WR: begin
        if (ctl.mem_ready)
          state_d = (state_q == S_FETCH) ? S_DECODE :
                    (state_q == S_MEM_RD) ? S_MEM_WB : S_FETCH;
        else if (timeout) begin
          state_d = S_TRAP;
          cause_d = TRAP_MEM_TO;
        end
      end
      S_DECODE: begin
        state_d = dec_legal ? dec_target : S_TRAP;
        if (!dec_legal) cause_d = TRAP_ILLEGAL;
      end
      S_MEM_ADR:   state_d = (ctl.opcode == OP_LOAD) ? S_MEM_RD : S_MEM_WR;
      S_MEM_WB, S_ALU_WB, S_BRANCH: state_d = S_FETCH;
      S_EXECUTE_R, S_EXECUTE_I, S_JAL, S_LINK, S_LUI, S_AUIPC: state_d = S_ALU_WB;
      S_JALR:      state_d = S_LINK;
      S_EXECUTE_M: if (md_done_w) state_d = S_FETCH;
      default:     state_d = S_TRAP;
    endcase

    cnt_d = cnt_q;
    if ((state_d != state_q) && is_mem_state(state_d)) cnt_d = '0;
    else if (is_mem_state(state_q) && !ctl.mem_ready)  cnt_d = cnt_q + CW'(1);

    out_d = moore_out(state_d, dec_alu_r, dec_alu_i);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_FETCH;
      cnt_q      <= '0;
      cause_q    <= TRAP_NONE;
      out_q      <= OUT_RST;
      md_start_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cause_q    <= cause_d;
      out_q      <= out_d;
      md_start_q <= md_start_d;
    end
  end

  // Reset kills every strobe and select combinationally, abandoning any access in flight
  assign run = !reset;

  assign ctl.mem_req     = run & out_q.mem_req;
  assign ctl.mem_write   = run & out_q.mem_write;
  assign ctl.adr_src     = run & out_q.adr_src;
  assign ctl.ir_write    = run & (state_q == S_FETCH) & ctl.mem_ready;
  assign ctl.pc_write    = run & (out_q.pc_write
                                  | ((state_q == S_FETCH)  & ctl.mem_ready)
                                  | ((state_q == S_BRANCH) & taken));
  assign ctl.reg_write   = run & (out_q.reg_write | ((state_q == S_EXECUTE_M) & md_done_w));
  assign ctl.retire      = run & (out_q.retire
                                  | ((state_q == S_MEM_WR)    & ctl.mem_ready)
                                  | ((state_q == S_EXECUTE_M) & md_done_w));
  assign ctl.md_start    = run & md_start_q;
  assign ctl.result_src  = run ? out_q.result_src  : 2'b00;
  assign ctl.alu_src_a   = run ? out_q.alu_src_a   : 2'b00;
  assign ctl.alu_src_b   = run ? out_q.alu_src_b   : 2'b00;
  assign ctl.alu_control = run ? out_q.alu_control : 4'b0000;
  assign ctl.imm_src     = run ? dec_imm           : 3'b000;
  assign ctl.trap_cause  = cause_q;
  assign ctl.current_state = state_q;

endmodule

// File: tb/tb_mc_control_rv32.sv
// Directed bench for mc_control_rv32 (MEM_TIMEOUT=4); mul/div scenario only with CTRL_MULDIV_EN.
module tb_mc_control_rv32;
  import rv_ctrl_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cmp = 0;
  int   err = 0;

  mc_control_rv32_if ifc ();

  mc_control_rv32 #(.MEM_TIMEOUT(4)) dut (.clk(clk), .reset(reset), .ctl(ifc));

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] strobes();
    return {ifc.mem_req, ifc.mem_write, ifc.adr_src, ifc.ir_write,
            ifc.pc_write, ifc.reg_write, ifc.retire, ifc.md_start};
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    ifc.mem_ready = 1'b0; ifc.md_done = 1'b0;
    ifc.zero = 1'b0; ifc.lt = 1'b0; ifc.ltu = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  task automatic set_ir(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
    ifc.opcode = op; ifc.funct3 = f3; ifc.funct7 = f7;
  endtask

  task automatic fetch_decode();
    ifc.mem_ready = 1'b1;
    tick();
    ifc.mem_ready = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    set_ir(OP_LOAD, 3'b010, 7'd0);
    ifc.mem_ready = 1'b1; ifc.md_done = 1'b0;
    ifc.zero = 1'b0; ifc.lt = 1'b0; ifc.ltu = 1'b0;
    reset = 1'b1;
    tick(); #1;
    cmp++; if (strobes() !== 8'h00) begin err++; $display("FAIL reset_strobes got=%b exp=00000000", strobes()); end
    cmp++; if ({ifc.result_src, ifc.alu_src_a, ifc.alu_src_b, ifc.alu_control, ifc.imm_src} !== 13'd0) begin
      err++; $display("FAIL reset_selects got=%b exp=0", {ifc.result_src, ifc.alu_src_a, ifc.alu_src_b, ifc.alu_control, ifc.imm_src}); end
    cmp++; if ({ifc.current_state, ifc.trap_cause} !== {S_FETCH, TRAP_NONE}) begin
      err++; $display("FAIL reset_state got=%0d/%0d exp=0/0", ifc.current_state, ifc.trap_cause); end
    ifc.mem_ready = 1'b0;
    reset = 1'b0; #1;
    cmp++; if ({ifc.mem_req, ifc.adr_src, ifc.alu_src_a, ifc.alu_src_b, ifc.alu_control} !== {1'b1, 1'b0, 2'b00, 2'b01, 4'b0000}) begin
      err++; $display("FAIL fetch_after_reset got=%b", {ifc.mem_req, ifc.adr_src, ifc.alu_src_a, ifc.alu_src_b, ifc.alu_control}); end
  endtask

  task automatic test_lw_waits();
    state_e     exp_st [8];
    logic [7:0] rdy;
    int         retires;
    exp_st = '{S_FETCH, S_FETCH, S_FETCH, S_DECODE, S_MEM_ADR, S_MEM_RD, S_MEM_RD, S_MEM_WB};
    rdy = 8'b0100_0100;
    retires = 0;
    do_reset();
    set_ir(OP_LOAD, 3'b010, 7'd0);
    for (int i = 0; i < 8; i++) begin
      ifc.mem_ready = rdy[i]; #1;
      cmp++; if (ifc.current_state !== exp_st[i]) begin
        err++; $display("FAIL lw_state cyc=%0d got=%0d exp=%0d", i, ifc.current_state, exp_st[i]); end
      if (ifc.retire === 1'b1) retires++;
      if (i == 5) begin
        cmp++; if ({ifc.mem_req, ifc.adr_src, ifc.mem_write} !== 3'b110) begin
          err++; $display("FAIL lw_memrd got=%b exp=110", {ifc.mem_req, ifc.adr_src, ifc.mem_write}); end
      end
      if (i == 7) begin
        cmp++; if ({ifc.result_src, ifc.reg_write} !== 3'b011) begin
          err++; $display("FAIL lw_wb got=%b exp=011", {ifc.result_src, ifc.reg_write}); end
      end
      tick();
    end
    ifc.mem_ready = 1'b0; #1;
    cmp++; if (ifc.current_state !== S_FETCH) begin err++; $display("FAIL lw_end got=%0d exp=0", ifc.current_state); end
    cmp++; if (retires != 1) begin err++; $display("FAIL lw_retires got=%0d exp=1", retires); end
  endtask

  task automatic test_store_and_reset_mid_wait();
    do_reset();
    set_ir(OP_STORE, 3'b010, 7'd0);
    fetch_decode(); #1;
    cmp++; if ({ifc.current_state, ifc.alu_src_a, ifc.alu_src_b, ifc.imm_src} !== {S_MEM_ADR, 2'b01, 2'b10, 3'b001}) begin
      err++; $display("FAIL sw_adr got=%0d a=%b b=%b imm=%b", ifc.current_state, ifc.alu_src_a, ifc.alu_src_b, ifc.imm_src); end
    tick(); #1;
    cmp++; if ({ifc.mem_req, ifc.mem_write, ifc.adr_src, ifc.retire} !== 4'b1110) begin
      err++; $display("FAIL sw_wait got=%b exp=1110", {ifc.mem_req, ifc.mem_write, ifc.adr_src, ifc.retire}); end
    tick(); ifc.mem_ready = 1'b1; #1;
    cmp++; if ({ifc.mem_write, ifc.retire, ifc.reg_write} !== 3'b110) begin
      err++; $display("FAIL sw_done got=%b exp=110", {ifc.mem_write, ifc.retire, ifc.reg_write}); end
    tick(); ifc.mem_ready = 1'b0; #1;
    cmp++; if (ifc.current_state !== S_FETCH) begin err++; $display("FAIL sw_end got=%0d exp=0", ifc.current_state); end
    fetch_decode(); tick(); #1;
    cmp++; if ({ifc.current_state, ifc.mem_write} !== {S_MEM_WR, 1'b1}) begin
      err++; $display("FAIL sw2_wr got=%0d/%b", ifc.current_state, ifc.mem_write); end
    reset = 1'b1; #1;
    cmp++; if ({ifc.current_state, ifc.mem_write, ifc.mem_req} !== {S_FETCH, 2'b00}) begin
      err++; $display("FAIL reset_mid_wr got=%0d/%b%b exp=0/00", ifc.current_state, ifc.mem_write, ifc.mem_req); end
    tick();
    reset = 1'b0;
  endtask

  task automatic test_branch();
    logic [5:0] vec [6];
    logic [5:0] tk;
    vec = '{6'b000100, 6'b001100, 6'b100010, 6'b101000, 6'b110000, 6'b111001};
    tk  = 6'b001101;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      set_ir(OP_BRANCH, vec[i][5:3], 7'd0);
      {ifc.zero, ifc.lt, ifc.ltu} = vec[i][2:0];
      ifc.mem_ready = 1'b1; #1;
      cmp++; if ({ifc.ir_write, ifc.pc_write, ifc.result_src} !== 4'b1110) begin
        err++; $display("FAIL br_fetch i=%0d got=%b exp=1110", i, {ifc.ir_write, ifc.pc_write, ifc.result_src}); end
      tick(); ifc.mem_ready = 1'b0; tick(); #1;
      cmp++; if ({ifc.current_state, ifc.pc_write, ifc.retire, ifc.alu_control, ifc.alu_src_a, ifc.alu_src_b, ifc.result_src}
                 !== {S_BRANCH, tk[i], 1'b1, 4'b1000, 2'b01, 2'b00, 2'b00}) begin
        err++; $display("FAIL br_exec i=%0d st=%0d pcw=%b ret=%b alu=%b exp_taken=%b", i, ifc.current_state, ifc.pc_write, ifc.retire, ifc.alu_control, tk[i]); end
      tick();
    end
    #1;
    cmp++; if (ifc.current_state !== S_FETCH) begin err++; $display("FAIL br_end got=%0d exp=0", ifc.current_state); end
  endtask

  task automatic test_jumps();
    do_reset();
    set_ir(OP_JALR, 3'b000, 7'd0);
    fetch_decode(); #1;
    cmp++; if ({ifc.current_state, ifc.pc_write, ifc.result_src, ifc.alu_src_a, ifc.alu_src_b, ifc.reg_write}
               !== {S_JALR, 1'b1, 2'b10, 2'b01, 2'b10, 1'b0}) begin
      err++; $display("FAIL jalr st=%0d pcw=%b res=%b", ifc.current_state, ifc.pc_write, ifc.result_src); end
    tick(); #1;
    cmp++; if ({ifc.current_state, ifc.pc_write, ifc.alu_src_a, ifc.alu_src_b} !== {S_LINK, 1'b0, 2'b10, 2'b01}) begin
      err++; $display("FAIL link st=%0d pcw=%b a=%b b=%b", ifc.current_state, ifc.pc_write, ifc.alu_src_a, ifc.alu_src_b); end
    tick(); #1;
    cmp++; if ({ifc.current_state, ifc.reg_write, ifc.retire, ifc.result_src} !== {S_ALU_WB, 2'b11, 2'b00}) begin
      err++; $display("FAIL jalr_wb st=%0d rw=%b ret=%b res=%b", ifc.current_state, ifc.reg_write, ifc.retire, ifc.result_src); end
    tick(); #1;
    cmp++; if (ifc.current_state !== S_FETCH) begin err++; $display("FAIL jalr_end got=%0d exp=0", ifc.current_state); end
    set_ir(OP_JAL, 3'b000, 7'd0);
    fetch_decode(); #1;
    cmp++; if ({ifc.current_state, ifc.pc_write, ifc.result_src, ifc.alu_src_a, ifc.alu_src_b, ifc.imm_src}
               !== {S_JAL, 1'b1, 2'b00, 2'b10, 2'b01, 3'b100}) begin
      err++; $display("FAIL jal st=%0d pcw=%b a=%b b=%b imm=%b", ifc.current_state, ifc.pc_write, ifc.alu_src_a, ifc.alu_src_b, ifc.imm_src); end
    tick(); tick(); #1;
    cmp++; if (ifc.current_state !== S_FETCH) begin err++; $display("FAIL jal_end got=%0d exp=0", ifc.current_state); end
  endtask

  task automatic test_alu_ops();
    logic [16:0] ir  [6];
    state_e      st  [6];
    logic [10:0] sel [6];
    ir  = '{{OP_OP, 3'b000, 7'b0100000}, {OP_OPIMM, 3'b101, 7'b0100000}, {OP_OPIMM, 3'b110, 7'b0100000},
            {OP_LUI, 3'b000, 7'd0}, {OP_AUIPC, 3'b000, 7'd0}, {OP_OP, 3'b001, 7'd0}};
    st  = '{S_EXECUTE_R, S_EXECUTE_I, S_EXECUTE_I, S_LUI, S_AUIPC, S_EXECUTE_R};
    sel = '{{2'b01, 2'b00, 4'b1000, 3'b000}, {2'b01, 2'b10, 4'b1101, 3'b000}, {2'b01, 2'b10, 4'b0110, 3'b000},
            {2'b11, 2'b10, 4'b0000, 3'b011}, {2'b10, 2'b10, 4'b0000, 3'b011}, {2'b01, 2'b00, 4'b0001, 3'b000}};
    do_reset();
    for (int i = 0; i < 6; i++) begin
      set_ir(ir[i][16:10], ir[i][9:7], ir[i][6:0]);
      fetch_decode(); #1;
      cmp++; if ({ifc.current_state, ifc.alu_src_a, ifc.alu_src_b, ifc.alu_control, ifc.imm_src} !== {st[i], sel[i]}) begin
        err++; $display("FAIL alu_exec i=%0d st=%0d sel=%b exp=%0d/%b", i, ifc.current_state,
                        {ifc.alu_src_a, ifc.alu_src_b, ifc.alu_control, ifc.imm_src}, st[i], sel[i]); end
      tick(); #1;
      cmp++; if ({ifc.current_state, ifc.reg_write, ifc.retire, ifc.result_src} !== {S_ALU_WB, 2'b11, 2'b00}) begin
        err++; $display("FAIL alu_wb i=%0d st=%0d rw=%b", i, ifc.current_state, ifc.reg_write); end
      tick();
    end
  endtask

  task automatic test_illegal();
    logic [16:0] bad [11];
    int          n;
    bad = '{{OP_BRANCH, 3'b010, 7'd0}, {OP_BRANCH, 3'b011, 7'd0}, {OP_LOAD, 3'b011, 7'd0},
            {OP_LOAD, 3'b110, 7'd0}, {OP_STORE, 3'b011, 7'd0}, {OP_STORE, 3'b111, 7'd0},
            {OP_OP, 3'b001, 7'b0100000}, {OP_OP, 3'b000, 7'b0000010}, {OP_OPIMM, 3'b001, 7'b0100000},
            {OP_OPIMM, 3'b101, 7'b0000001}, {OP_OP, 3'b000, 7'b0000001}};
`ifdef CTRL_MULDIV_EN
    n = 10;
`else
    n = 11;
`endif
    do_reset();
    set_ir(7'h7F, 3'b000, 7'd0);
    fetch_decode(); #1;
    cmp++; if ({ifc.current_state, ifc.trap_cause} !== {S_TRAP, TRAP_ILLEGAL}) begin
      err++; $display("FAIL ill_trap got=%0d/%b exp=16/01", ifc.current_state, ifc.trap_cause); end
    ifc.md_done = 1'b1; ifc.zero = 1'b1;
    for (int i = 0; i < 20; i++) begin
      ifc.mem_ready = i[0]; #1;
      cmp++; if ({strobes(), ifc.current_state, ifc.trap_cause} !== {8'h00, S_TRAP, TRAP_ILLEGAL}) begin
        err++; $display("FAIL trap_hold cyc=%0d strobes=%b st=%0d cause=%b", i, strobes(), ifc.current_state, ifc.trap_cause); end
      tick();
    end
    for (int i = 0; i < n; i++) begin
      do_reset();
      set_ir(bad[i][16:10], bad[i][9:7], bad[i][6:0]);
      fetch_decode(); #1;
      cmp++; if ({ifc.current_state, ifc.trap_cause} !== {S_TRAP, TRAP_ILLEGAL}) begin
        err++; $display("FAIL ill_enc i=%0d got=%0d/%b exp=16/01", i, ifc.current_state, ifc.trap_cause); end
    end
  endtask

  task automatic test_timeout();
    do_reset();
    set_ir(OP_LOAD, 3'b010, 7'd0);
    for (int i = 0; i < 5; i++) begin
      #1;
      cmp++; if ({ifc.current_state, ifc.mem_req} !== {S_FETCH, 1'b1}) begin
        err++; $display("FAIL to_wait cyc=%0d got=%0d/%b", i, ifc.current_state, ifc.mem_req); end
      tick();
    end
    #1;
    cmp++; if ({ifc.current_state, ifc.trap_cause, ifc.mem_req} !== {S_TRAP, TRAP_MEM_TO, 1'b0}) begin
      err++; $display("FAIL to_trap got=%0d/%b/%b exp=16/10/0", ifc.current_state, ifc.trap_cause, ifc.mem_req); end
    do_reset();
    for (int i = 0; i < 5; i++) begin
      ifc.mem_ready = (i == 4); tick();
    end
    ifc.mem_ready = 1'b0; #1;
    cmp++; if (ifc.current_state !== S_DECODE) begin err++; $display("FAIL to_ready_last got=%0d exp=1", ifc.current_state); end
    // FETCH waits 3, then MEM_RD waits 4: survives only if the counter restarts on MEM_RD entry
    do_reset();
    for (int i = 0; i < 4; i++) begin ifc.mem_ready = (i == 3); tick(); end
    ifc.mem_ready = 1'b0; tick(); tick();
    for (int i = 0; i < 5; i++) begin ifc.mem_ready = (i == 4); tick(); end
    ifc.mem_ready = 1'b0; #1;
    cmp++; if (ifc.current_state !== S_MEM_WB) begin err++; $display("FAIL to_clear got=%0d exp=4", ifc.current_state); end
    tick(); fetch_decode(); tick();
    for (int i = 0; i < 5; i++) tick();
    #1;
    cmp++; if ({ifc.current_state, ifc.trap_cause} !== {S_TRAP, TRAP_MEM_TO}) begin
      err++; $display("FAIL to_memrd got=%0d/%b exp=16/10", ifc.current_state, ifc.trap_cause); end
  endtask

`ifdef CTRL_MULDIV_EN
  task automatic test_muldiv();
    int pulses;
    pulses = 0;
    do_reset();
    set_ir(OP_OP, 3'b000, 7'b0000001);
    fetch_decode();
    for (int i = 0; i < 4; i++) begin
      ifc.md_done = (i == 3); #1;
      if (ifc.md_start === 1'b1) pulses++;
      if (i == 0) begin
        cmp++; if ({ifc.current_state, ifc.md_start} !== {S_EXECUTE_M, 1'b1}) begin
          err++; $display("FAIL md_entry got=%0d/%b", ifc.current_state, ifc.md_start); end
      end
      cmp++; if ({ifc.reg_write, ifc.retire, ifc.result_src} !== ((i == 3) ? 4'b1111 : 4'b0011)) begin
        err++; $display("FAIL md_wb cyc=%0d got=%b", i, {ifc.reg_write, ifc.retire, ifc.result_src}); end
      tick();
    end
    ifc.md_done = 1'b0; #1;
    cmp++; if (ifc.current_state !== S_FETCH) begin err++; $display("FAIL md_end got=%0d exp=0", ifc.current_state); end
    cmp++; if (pulses != 1) begin err++; $display("FAIL md_pulses got=%0d exp=1", pulses); end
  endtask
`endif

  initial begin
    test_reset();
    test_lw_waits();
    test_store_and_reset_mid_wait();
    test_branch();
    test_jumps();
    test_alu_ops();
    test_illegal();
    test_timeout();
`ifdef CTRL_MULDIV_EN
    test_muldiv();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, err);
    $finish;
  end

endmodule
